// File: rtl/axis_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : axis_uart_frame_rx
// Purpose  : Frame parser behind a UART byte receiver. Finds SOF/LEN/payload
//            (plus optional XOR checksum) frames, buffers the payload and
//            releases it on an AXI-Stream master with tlast once validated.
//            Bad length, bad checksum and inter-byte timeouts drop the frame
//            and raise a one-cycle flag.
// Options  : define AXIS_UART_FRAME_CHK_EN to require the trailing CHK byte
//            (XOR of LEN and all payload bytes). Undefined: frame ends after
//            the last payload byte and err_chk_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module axis_uart_frame_rx #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  input  logic       m_axis_tready,
  output logic       frame_ok_o,
  output logic       err_len_o,
  output logic       err_chk_o,
  output logic       err_timeout_o
);

  localparam int c_cnt_w = $clog2(MAX_LEN + 1);
  localparam int c_adr_w = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]         c_max_len  = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]         r_buf [MAX_LEN];
  logic [c_cnt_w-1:0] r_len;
  logic [c_cnt_w-1:0] r_wr_idx;
  logic [c_cnt_w-1:0] r_rd_idx;
  logic [c_tmo_w-1:0] r_tmo;

  logic r_frame_ok;
  logic r_err_len;
  logic r_err_tmo;

  logic w_acc;
  logic w_sof;
  logic w_in_frame;
  logic w_len_bad;
  logic w_pay_last;
  logic w_out_last;
  logic w_tmo_hit;
  logic w_load_len;
  logic w_wr_en;
  logic w_rd_inc;
  logic w_ok;
  logic w_len_err;
  logic w_tmo_err;
  logic w_chk_err;

`ifdef AXIS_UART_FRAME_CHK_EN
  logic [7:0] r_xor;
  logic       r_err_chk;
`endif

  // Input readiness depends on state only; OUT blocks new bytes.
  assign s_axis_tready = (r_state != S_OUT);
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_sof         = w_acc && (r_state == S_IDLE) && (s_axis_tdata == SOF_BYTE);
  assign w_in_frame    = (r_state == S_LEN) || (r_state == S_PAY) || (r_state == S_CHK);
  assign w_len_bad     = (s_axis_tdata == 8'd0) || ({1'b0, s_axis_tdata} > c_max_len);
  assign w_pay_last    = (r_wr_idx == (r_len - c_cnt_one));
  assign w_out_last    = (r_rd_idx == (r_len - c_cnt_one));
  assign w_tmo_hit     = (r_tmo == c_tmo_last);

  assign m_axis_tvalid = (r_state == S_OUT);
  assign m_axis_tlast  = m_axis_tvalid && w_out_last;
  assign m_axis_tdata  = m_axis_tvalid ? r_buf[r_rd_idx[c_adr_w-1:0]] : 8'h00;
  assign w_rd_inc      = m_axis_tvalid && m_axis_tready;

  assign frame_ok_o    = r_frame_ok;
  assign err_len_o     = r_err_len;
  assign err_timeout_o = r_err_tmo;

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath strobes; accepted bytes take priority over
  // a timeout expiring on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load_len  = 1'b0;
    w_wr_en     = 1'b0;
    w_ok        = 1'b0;
    w_len_err   = 1'b0;
    w_tmo_err   = 1'b0;
    w_chk_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_sof) begin
          w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (w_acc) begin
          if (w_len_bad) begin
            w_len_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load_len  = 1'b1;
            w_state_nxt = S_PAY;
          end
        end else if (w_tmo_hit) begin
          w_tmo_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PAY: begin
        if (w_acc) begin
          w_wr_en = 1'b1;
          if (w_pay_last) begin
`ifdef AXIS_UART_FRAME_CHK_EN
            w_state_nxt = S_CHK;
`else
            w_ok        = 1'b1;
            w_state_nxt = S_OUT;
`endif
          end
        end else if (w_tmo_hit) begin
          w_tmo_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef AXIS_UART_FRAME_CHK_EN
      S_CHK: begin
        if (w_acc) begin
          if (s_axis_tdata == r_xor) begin
            w_ok        = 1'b1;
            w_state_nxt = S_OUT;
          end else begin
            w_chk_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_tmo_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      S_OUT: begin
        if (w_rd_inc && w_out_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Length, index and inter-byte timeout counters plus registered pulses.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_len      <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_tmo      <= '0;
      r_frame_ok <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      if (w_load_len) begin
        r_len    <= s_axis_tdata[c_cnt_w-1:0];
        r_wr_idx <= '0;
      end else if (w_wr_en) begin
        r_wr_idx <= r_wr_idx + c_cnt_one;
      end

      if (w_ok) begin
        r_rd_idx <= '0;
      end else if (w_rd_inc) begin
        r_rd_idx <= r_rd_idx + c_cnt_one;
      end

      // Cleared by any accepted byte (including the SOF that enters LEN);
      // only counts while a frame is being received.
      if (w_acc || !w_in_frame) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + c_tmo_one;
      end

      r_frame_ok <= w_ok;
      r_err_len  <= w_len_err;
      r_err_tmo  <= w_tmo_err;
    end
  end

  // Payload storage; contents are only meaningful after a valid frame.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_buf[r_wr_idx[c_adr_w-1:0]] <= s_axis_tdata;
    end
  end

`ifdef AXIS_UART_FRAME_CHK_EN
  // Running XOR of LEN and payload, restarted on every SOF.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_xor     <= 8'h00;
      r_err_chk <= 1'b0;
    end else begin
      if (w_sof) begin
        r_xor <= 8'h00;
      end else if (w_load_len) begin
        r_xor <= s_axis_tdata;
      end else if (w_wr_en) begin
        r_xor <= r_xor ^ s_axis_tdata;
      end
      r_err_chk <= w_chk_err;
    end
  end

  assign err_chk_o = r_err_chk;
`else
  assign err_chk_o = 1'b0;
`endif

endmodule
`default_nettype wire
